// File: rtl/simon_seq_store.sv
// Simon Says sequence store: append symbols, replay them over valid/ready,
// then check the player's presses in order against the stored sequence.
module simon_seq_store #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             append,
   input  logic [SYM_W-1:0] append_sym,
   output logic             append_err,
   input  logic             play_start,
   output logic             play_valid,
   output logic [SYM_W-1:0] play_sym,
   input  logic             play_ready,
   output logic             play_done,
   input  logic             chk_valid,
   input  logic [SYM_W-1:0] chk_sym,
   output logic             chk_match,
   output logic             chk_fail,
   output logic             chk_round_ok,
   output logic [AW:0]      length,
   output logic             full,
   output logic             busy
);

   localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK} state_t;

   state_t           state_q, state_d;
   logic [AW:0]      length_q, length_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [SYM_W-1:0] mem_q [DEPTH];
   logic             wr_en;
   logic             idx_last;
   logic             append_err_q, append_err_d;
   logic             play_done_q, play_done_d;
   logic             chk_match_q, chk_match_d;
   logic             chk_fail_q, chk_fail_d;
   logic             chk_round_ok_q, chk_round_ok_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         length_q       <= '0;
         idx_q          <= '0;
         append_err_q   <= 1'b0;
         play_done_q    <= 1'b0;
         chk_match_q    <= 1'b0;
         chk_fail_q     <= 1'b0;
         chk_round_ok_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         length_q       <= length_d;
         idx_q          <= idx_d;
         append_err_q   <= append_err_d;
         play_done_q    <= play_done_d;
         chk_match_q    <= chk_match_d;
         chk_fail_q     <= chk_fail_d;
         chk_round_ok_q <= chk_round_ok_d;
      end
   end

   // Contents are deliberately not reset; length_q alone qualifies them.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[length_q[AW-1:0]] <= append_sym;
      end
   end

   always_comb begin
      state_d        = state_q;
      length_d       = length_q;
      idx_d          = idx_q;
      wr_en          = 1'b0;
      append_err_d   = 1'b0;
      play_done_d    = 1'b0;
      chk_match_d    = 1'b0;
      chk_fail_d     = 1'b0;
      chk_round_ok_d = 1'b0;
      idx_last       = ({1'b0, idx_q} == (length_q - 1'b1));
      if (clear) begin
         state_d  = S_IDLE;
         length_d = '0;
         idx_d    = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (append) begin
                  if (length_q < DEPTH_V) begin
                     wr_en    = 1'b1;
                     length_d = length_q + 1'b1;
                  end else begin
                     append_err_d = 1'b1;
                  end
               end
               // Uses length_d so a same-cycle append is included in the replay.
               if (play_start) begin
                  if (length_d != '0) begin
                     state_d = S_PLAY;
                     idx_d   = '0;
                  end else begin
                     play_done_d = 1'b1;
                  end
               end
            end
            S_PLAY: begin
               append_err_d = append;
               if (play_ready) begin
                  if (idx_last) begin
                     play_done_d = 1'b1;
                     idx_d       = '0;
                     state_d     = S_CHECK;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end
            end
            S_CHECK: begin
               append_err_d = append;
               if (chk_valid) begin
                  if (chk_sym == mem_q[idx_q]) begin
                     chk_match_d = 1'b1;
                     if (idx_last) begin
                        chk_round_ok_d = 1'b1;
                        idx_d          = '0;
                        state_d        = S_IDLE;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end else begin
                     chk_fail_d = 1'b1;
                     idx_d      = '0;
                     state_d    = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      play_valid   = (state_q == S_PLAY);
      play_sym     = play_valid ? mem_q[idx_q] : '0;
      busy         = (state_q != S_IDLE);
      full         = (length_q == DEPTH_V);
      length       = length_q;
      append_err   = append_err_q;
      play_done    = play_done_q;
      chk_match    = chk_match_q;
      chk_fail     = chk_fail_q;
      chk_round_ok = chk_round_ok_q;
   end

endmodule

// File: tb/tb_simon_seq_store.sv
// Bench for simon_seq_store: directed vector table, hand-written corner
// sequences and a randomized run against a queue-based behavioural model.
module tb_simon_seq_store;

   localparam int SYM_W = 2;
   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             clear = 1'b0;
   logic             append = 1'b0;
   logic [SYM_W-1:0] append_sym = '0;
   logic             append_err;
   logic             play_start = 1'b0;
   logic             play_valid;
   logic [SYM_W-1:0] play_sym;
   logic             play_ready = 1'b0;
   logic             play_done;
   logic             chk_valid = 1'b0;
   logic [SYM_W-1:0] chk_sym = '0;
   logic             chk_match;
   logic             chk_fail;
   logic             chk_round_ok;
   logic [AW:0]      length;
   logic             full;
   logic             busy;

   simon_seq_store #(.SYM_W(SYM_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .append(append), .append_sym(append_sym), .append_err(append_err),
      .play_start(play_start), .play_valid(play_valid), .play_sym(play_sym),
      .play_ready(play_ready), .play_done(play_done),
      .chk_valid(chk_valid), .chk_sym(chk_sym), .chk_match(chk_match),
      .chk_fail(chk_fail), .chk_round_ok(chk_round_ok),
      .length(length), .full(full), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      int clr, app, asym, ps, rdy, cv, cs;
      int len, pv, psym, pdone, match, fail, rok, aerr, bsy;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   failures = 0;

   // Behavioural model: the sequence as a queue, an activity phase and a cursor.
   int m_seq[$];
   int m_phase = 0;   // 0 idle, 1 replaying, 2 checking
   int m_pos = 0;
   int e_aerr, e_pdone, e_match, e_fail, e_rok;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int clr, app, asym, ps, rdy, cv, cs,
                               len, pv, psym, pdone, match, fail, rok, aerr, bsy);
      vec_t v;
      v.clr = clr; v.app = app; v.asym = asym; v.ps = ps; v.rdy = rdy;
      v.cv = cv; v.cs = cs; v.len = len; v.pv = pv; v.psym = psym;
      v.pdone = pdone; v.match = match; v.fail = fail; v.rok = rok;
      v.aerr = aerr; v.bsy = bsy;
      return v;
   endfunction

   task automatic model_reset();
      m_seq.delete();
      m_phase = 0; m_pos = 0;
      e_aerr = 0; e_pdone = 0; e_match = 0; e_fail = 0; e_rok = 0;
   endtask

   task automatic model_step(input vec_t v);
      e_aerr = 0; e_pdone = 0; e_match = 0; e_fail = 0; e_rok = 0;
      if (v.clr != 0) begin
         m_seq.delete(); m_phase = 0; m_pos = 0;
         return;
      end
      if (m_phase == 0) begin
         if (v.app != 0) begin
            if (m_seq.size() < DEPTH) m_seq.push_back(v.asym);
            else e_aerr = 1;
         end
         if (v.ps != 0) begin
            if (m_seq.size() > 0) begin m_phase = 1; m_pos = 0; end
            else e_pdone = 1;
         end
      end else if (m_phase == 1) begin
         e_aerr = v.app;
         if (v.rdy != 0) begin
            if (m_pos == m_seq.size() - 1) begin e_pdone = 1; m_phase = 2; m_pos = 0; end
            else m_pos++;
         end
      end else begin
         e_aerr = v.app;
         if (v.cv != 0) begin
            if (v.cs == m_seq[m_pos]) begin
               e_match = 1;
               if (m_pos == m_seq.size() - 1) begin e_rok = 1; m_phase = 0; m_pos = 0; end
               else m_pos++;
            end else begin
               e_fail = 1; m_phase = 0; m_pos = 0;
            end
         end
      end
   endtask

   task automatic compare_model(input string tag);
      chk({tag, "_length"}, int'(length), m_seq.size());
      chk({tag, "_full"}, int'(full), int'(m_seq.size() == DEPTH));
      chk({tag, "_busy"}, int'(busy), int'(m_phase != 0));
      chk({tag, "_play_valid"}, int'(play_valid), int'(m_phase == 1));
      chk({tag, "_play_sym"}, int'(play_sym), (m_phase == 1) ? m_seq[m_pos] : 0);
      chk({tag, "_append_err"}, int'(append_err), e_aerr);
      chk({tag, "_play_done"}, int'(play_done), e_pdone);
      chk({tag, "_chk_match"}, int'(chk_match), e_match);
      chk({tag, "_chk_fail"}, int'(chk_fail), e_fail);
      chk({tag, "_chk_round_ok"}, int'(chk_round_ok), e_rok);
   endtask

   task automatic apply(input vec_t v, input string tag);
      @(negedge clock);
      clear = v.clr[0]; append = v.app[0]; append_sym = v.asym[SYM_W-1:0];
      play_start = v.ps[0]; play_ready = v.rdy[0];
      chk_valid = v.cv[0]; chk_sym = v.cs[SYM_W-1:0];
      model_step(v);
      @(posedge clock);
      #1;
      compare_model(tag);
   endtask

   initial begin
      vec_t v;
      model_reset();
      // clr app asym ps rdy cv cs | len pv psym pdone match fail rok aerr busy
      tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,1,1,0,0,0,0, 2,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,1,2,0,0,0,0, 3,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,1,1,0,0, 3,1,3,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 3,1,1,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 3,1,2,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 3,0,0,1,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,1,3, 3,0,0,0,1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,1,1, 3,0,0,0,1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,1,2, 3,0,0,0,1,0,1,0,0));
      tbl.push_back(mk(0,0,0,1,0,0,0, 3,1,3,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 3,1,1,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0, 3,1,1,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 3,1,2,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,0,0, 3,1,2,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 3,0,0,1,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,1,3, 3,0,0,0,1,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,0,1,0, 3,0,0,0,0,1,0,0,0));
      tbl.push_back(mk(0,0,0,1,0,0,0, 3,1,3,0,0,0,0,0,1));
      tbl.push_back(mk(0,1,2,0,0,0,0, 3,1,3,0,0,0,0,1,1));
      tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,1,1,0,0, 0,0,0,1,0,0,0,0,0));
      tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,0,0,0,0,0,0,0));
      tbl.push_back(mk(0,1,2,1,0,0,0, 2,1,0,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,1,2,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,1,0,0, 2,0,0,1,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));

      repeat (2) @(posedge clock);
      #1;
      chk("reset_length", int'(length), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_play_valid", int'(play_valid), 0);
      chk("reset_full", int'(full), 0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d_len", i), int'(length), tbl[i].len);
         chk($sformatf("tbl%0d_pv", i), int'(play_valid), tbl[i].pv);
         chk($sformatf("tbl%0d_psym", i), int'(play_sym), tbl[i].psym);
         chk($sformatf("tbl%0d_pdone", i), int'(play_done), tbl[i].pdone);
         chk($sformatf("tbl%0d_match", i), int'(chk_match), tbl[i].match);
         chk($sformatf("tbl%0d_fail", i), int'(chk_fail), tbl[i].fail);
         chk($sformatf("tbl%0d_rok", i), int'(chk_round_ok), tbl[i].rok);
         chk($sformatf("tbl%0d_aerr", i), int'(append_err), tbl[i].aerr);
         chk($sformatf("tbl%0d_busy", i), int'(busy), tbl[i].bsy);
      end

      // Fill to DEPTH, then overflow.
      for (int i = 0; i < DEPTH; i++) begin
         apply(mk(0,1,int'($urandom_range(3)),0,0,0,0, 0,0,0,0,0,0,0,0,0), "fill");
      end
      chk("full_flag", int'(full), 1);
      chk("full_length", int'(length), DEPTH);
      apply(mk(0,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0), "overflow");
      chk("overflow_err", int'(append_err), 1);
      chk("overflow_length", int'(length), DEPTH);
      // Full + play_start: append rejected, replay still starts.
      apply(mk(0,1,1,1,0,0,0, 0,0,0,0,0,0,0,0,0), "full_ps");
      chk("full_ps_err", int'(append_err), 1);
      chk("full_ps_valid", int'(play_valid), 1);
      apply(mk(0,1,2,0,0,0,0, 0,0,0,0,0,0,0,0,0), "app_in_play");
      chk("app_in_play_err", int'(append_err), 1);

      // Clear mid-PLAY.
      apply(mk(0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0), "pre_clr");
      apply(mk(1,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0), "clr_play");
      chk("clr_play_len", int'(length), 0);
      chk("clr_play_pdone", int'(play_done), 0);

      // Reset mid-CHECK, observed before the next clock edge.
      apply(mk(0,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0), "r_app");
      apply(mk(0,1,3,1,1,0,0, 0,0,0,0,0,0,0,0,0), "r_ps");
      for (int i = 0; i < 8 && m_phase != 2; i++) begin
         apply(mk(0,0,0,0,1,0,0, 0,0,0,0,0,0,0,0,0), "r_play");
      end
      chk("r_in_check", int'(busy && !play_valid), 1);
      apply(mk(0,0,0,0,0,1,1, 0,0,0,0,0,0,0,0,0), "r_press");
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_len", int'(length), 0);
      chk("async_rst_pv", int'(play_valid), 0);
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      // Randomized run; presses mostly follow the model so rounds complete.
      for (int n = 0; n < 3000; n++) begin
         v = mk(($urandom_range(59) == 0) ? 1 : 0,
                ($urandom_range(3) == 0) ? 1 : 0, int'($urandom_range(3)),
                ($urandom_range(5) == 0) ? 1 : 0, int'($urandom_range(1)),
                int'($urandom_range(1)), int'($urandom_range(3)),
                0,0,0,0,0,0,0,0,0);
         if (m_phase == 2 && $urandom_range(9) < 8) v.cs = m_seq[m_pos];
         apply(v, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
